// File: rtl/jtpopeye_pkg.sv
// Shared state encoding and defaults for the Popeye object DMA slice.
package jtpopeye_pkg;

    localparam int OBJ_LEN = 160;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_RD,
        ST_CAP,
        ST_WR,
        ST_REL
    } objdma_state_t;

endpackage

// File: rtl/jtpopeye_edge.sv
// Clock-enable gated rising-edge detector for blanking and similar strobes.
module jtpopeye_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic cen,
    input  logic sig,
    output logic rise
);

    logic sig_l;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sig_l <= 1'b0;
        else if (cen)
            sig_l <= sig;
    end

    assign rise = sig & ~sig_l;

endmodule

// File: rtl/jtpopeye_objdma.sv
// Object DMA: copies the sprite table from CPU work RAM into object RAM at
// vertical blank, holding the CPU bus through a BUSRQ/BUSAK handshake.
module jtpopeye_objdma
    import jtpopeye_pkg::*;
#(
    parameter int LEN = OBJ_LEN,
    parameter int SAW = 12,
    parameter int DW  = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           pxl2_cen,
    input  logic           VB,
    input  logic           dma_trig,
    input  logic [SAW-9:0] dma_page,
    output logic           busrq_n,
    input  logic           busak_n,
    output logic [SAW-1:0] src_addr,
    input  logic [DW-1:0]  src_din,
    output logic [7:0]     obj_addr,
    output logic [DW-1:0]  obj_dout,
    output logic           obj_we,
    output logic           dma_busy
);

    localparam logic [7:0] LAST = 8'(LEN - 1);

    objdma_state_t  state, state_nx;
    logic           armed, arm_now, vb_rise;
    logic [SAW-9:0] page_l;
    logic [7:0]     idx, idx_nx, obj_addr_nx;
    logic [SAW-1:0] src_addr_nx;
    logic [DW-1:0]  obj_dout_nx;
    logic           busrq_nx, we_r, we_nx;

    jtpopeye_edge u_vb_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .cen   (pxl2_cen),
        .sig   (VB),
        .rise  (vb_rise)
    );

    // Arming is sampled every clk; an arm in the same clk as the VB rise counts.
    assign arm_now = dma_trig & ~armed & (state == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed  <= 1'b0;
            page_l <= '0;
        end else if (pxl2_cen && state == ST_REL) begin
            armed  <= 1'b0;
        end else if (arm_now) begin
            armed  <= 1'b1;
            page_l <= dma_page;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            busrq_n  <= 1'b1;
            src_addr <= '0;
            obj_addr <= '0;
            obj_dout <= '0;
            we_r     <= 1'b0;
            idx      <= '0;
        end else if (pxl2_cen) begin
            state    <= state_nx;
            busrq_n  <= busrq_nx;
            src_addr <= src_addr_nx;
            obj_addr <= obj_addr_nx;
            obj_dout <= obj_dout_nx;
            we_r     <= we_nx;
            idx      <= idx_nx;
        end
    end

    // Losing BUSAK mid-copy holds RD/CAP/WR in place; a held WR replays its write on reacquire.
    always_comb begin
        state_nx    = state;
        busrq_nx    = busrq_n;
        src_addr_nx = src_addr;
        obj_addr_nx = obj_addr;
        obj_dout_nx = obj_dout;
        we_nx       = we_r;
        idx_nx      = idx;
        case (state)
            ST_IDLE: if ((armed | arm_now) && vb_rise) begin
                state_nx = ST_REQ;
                busrq_nx = 1'b0;
                idx_nx   = '0;
            end
            ST_REQ: if (!busak_n) state_nx = ST_RD;
            ST_RD: if (!busak_n) begin
                src_addr_nx = {page_l, idx};
                state_nx    = ST_CAP;
            end
            ST_CAP: if (!busak_n) begin
                obj_dout_nx = src_din;
                obj_addr_nx = idx;
                we_nx       = 1'b1;
                state_nx    = ST_WR;
            end
            ST_WR: if (!busak_n) begin
                we_nx = 1'b0;
                if (idx == LAST) begin
                    state_nx = ST_REL;
                end else begin
                    idx_nx   = idx + 8'd1;
                    state_nx = ST_RD;
                end
            end
            ST_REL: begin
                busrq_nx = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign obj_we   = we_r & ~busak_n;
    assign dma_busy = armed | (state != ST_IDLE);

endmodule

// File: tb/tb_jtpopeye_objdma.sv
// Bench for jtpopeye_objdma: a table of transfer scenarios plus random ones,
// checked against a work-RAM model and a delayed-BUSAK CPU model.
module tb_jtpopeye_objdma;

    localparam int LEN = 160;
    localparam int SAW = 12;

    typedef struct {
        int page;
        int pause_idx;
        bit pause_wr;
        bit retrig;
        int retrig_page;
        int exp_cyc;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pxl2_cen = 1'b0;
    logic       VB = 1'b0;
    logic       dma_trig = 1'b0;
    logic [3:0] dma_page = '0;

    logic        busrq_n_v [2];
    logic        busak_n_v [2];
    logic        obj_we_v  [2];
    logic        dma_busy_v[2];
    logic [11:0] src_addr_v[2];
    logic [7:0]  src_din_v [2];
    logic [7:0]  obj_addr_v[2];
    logic [7:0]  obj_dout_v[2];
    logic [7:0]  ram [0:4095];

    int unsigned total = 0;
    int unsigned bad = 0;
    int  cen_cnt = 0;
    logic d1[2], d2[2];
    int  t0[2], t1[2], wr_cnt[2];
    bit  t0_seen[2], t1_seen[2], rq_seen[2];
    logic [7:0]  wr_addr[2][512];
    logic [7:0]  wr_data[2][512];
    logic [11:0] wr_src [2][512];
    int  pause_cnt = 0, pause_idx = -1, pause_base = 0, gap_we = 0;
    bit  pause_wr = 0, pause_done = 0, cen_force = 0;
    vec_t vecs[5];

    always #5 clk = ~clk;

    jtpopeye_objdma #(.LEN(LEN), .SAW(SAW), .DW(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .pxl2_cen(pxl2_cen), .VB(VB),
        .dma_trig(dma_trig), .dma_page(dma_page),
        .busrq_n(busrq_n_v[0]), .busak_n(busak_n_v[0]),
        .src_addr(src_addr_v[0]), .src_din(src_din_v[0]),
        .obj_addr(obj_addr_v[0]), .obj_dout(obj_dout_v[0]),
        .obj_we(obj_we_v[0]), .dma_busy(dma_busy_v[0])
    );

    jtpopeye_objdma #(.LEN(1), .SAW(SAW), .DW(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .pxl2_cen(pxl2_cen), .VB(VB),
        .dma_trig(dma_trig), .dma_page(dma_page),
        .busrq_n(busrq_n_v[1]), .busak_n(busak_n_v[1]),
        .src_addr(src_addr_v[1]), .src_din(src_din_v[1]),
        .obj_addr(obj_addr_v[1]), .obj_dout(obj_dout_v[1]),
        .obj_we(obj_we_v[1]), .dma_busy(dma_busy_v[1])
    );

    assign src_din_v[0] = ram[src_addr_v[0]];
    assign src_din_v[1] = ram[src_addr_v[1]];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clk step: inputs change on the falling edge, outputs are sampled 1ns later.
    task automatic tick();
        @(negedge clk);
        if (pxl2_cen) begin
            cen_cnt++;
            for (int i = 0; i < 2; i++) begin
                d2[i] = d1[i];
                d1[i] = busrq_n_v[i];
            end
            if (pause_cnt > 0) pause_cnt--;
        end
        for (int i = 0; i < 2; i++)
            if (t0_seen[i] && !t1_seen[i] && busrq_n_v[i]) begin
                t1_seen[i] = 1;
                t1[i] = cen_cnt;
            end
        if (pause_idx >= 0 && !pause_done) begin
            if (pause_wr ? (obj_we_v[0] && obj_addr_v[0] == 8'(pause_idx))
                         : (!obj_we_v[0] && !busrq_n_v[0] && t0_seen[0] && wr_cnt[0] == pause_idx &&
                            src_addr_v[0] == 12'(pause_base + pause_idx))) begin
                pause_cnt  = 5;
                pause_done = 1;
            end
        end
        for (int i = 0; i < 2; i++) busak_n_v[i] = d2[i];
        if (pause_cnt > 0) busak_n_v[0] = 1'b1;
        pxl2_cen = cen_force ? 1'b1 : ($urandom_range(0, 2) != 0);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (!busrq_n_v[i]) rq_seen[i] = 1;
            if (pxl2_cen && obj_we_v[i] && wr_cnt[i] < 512) begin
                wr_addr[i][wr_cnt[i]] = obj_addr_v[i];
                wr_data[i][wr_cnt[i]] = obj_dout_v[i];
                wr_src[i][wr_cnt[i]]  = src_addr_v[i];
                wr_cnt[i]++;
            end
            if (pxl2_cen && !busak_n_v[i] && !busrq_n_v[i] && !t0_seen[i]) begin
                t0_seen[i] = 1;
                t0[i] = cen_cnt + 1;
            end
        end
        if (pause_cnt > 0 && obj_we_v[0]) gap_we++;
    endtask

    task automatic clear_mon();
        for (int i = 0; i < 2; i++) begin
            wr_cnt[i]  = 0;
            t0_seen[i] = 0;
            t1_seen[i] = 0;
            rq_seen[i] = 0;
        end
        pause_idx  = -1;
        pause_done = 0;
        pause_cnt  = 0;
        gap_we     = 0;
    endtask

    task automatic vb_low();
        VB = 1'b0;
        cen_force = 1;
        tick();
        tick();
        cen_force = 0;
    endtask

    task automatic check_copy(input int i, input int page, input int len, input int exp_cyc);
        chk("write_count", wr_cnt[i], len);
        for (int k = 0; k < len && k < wr_cnt[i]; k++) begin
            chk("obj_addr", int'(wr_addr[i][k]), k);
            chk("obj_dout", int'(wr_data[i][k]), int'(ram[page * 256 + k]));
            chk("src_addr", int'(wr_src[i][k]), page * 256 + k);
        end
        if (exp_cyc > 0) chk("bus_cycles", t1[i] - t0[i], exp_cyc);
        chk("busy_after", int'(dma_busy_v[i]), 0);
    endtask

    task automatic run_transfer(input vec_t v);
        bit retrig_done;
        int n;
        retrig_done = 0;
        n = 0;
        vb_low();
        clear_mon();
        pause_idx  = v.pause_idx;
        pause_wr   = v.pause_wr;
        pause_base = v.page * 256;
        dma_page = 4'(v.page);
        dma_trig = 1'b1;
        tick();
        dma_trig = 1'b0;
        dma_page = 4'($urandom);
        chk("busy_armed", int'(dma_busy_v[0]), 1);
        VB = 1'b1;
        while (!t1_seen[0] && n < 4000) begin
            tick();
            n++;
            if (wr_cnt[0] >= 50) VB = 1'b0;
            if (v.retrig && !retrig_done && wr_cnt[0] >= 80) begin
                dma_page = 4'(v.retrig_page);
                dma_trig = 1'b1;
                tick();
                n++;
                dma_trig = 1'b0;
                retrig_done = 1;
            end
        end
        chk("done_timeout", int'(t1_seen[0]), 1);
        check_copy(0, v.page, LEN, v.exp_cyc);
        if (v.pause_idx >= 0) begin
            chk("pause_hit", int'(pause_done), 1);
            chk("gap_we", gap_we, 0);
        end
        if (v.retrig) begin
            vb_low();
            clear_mon();
            VB = 1'b1;
            repeat (60) tick();
            chk("retrig_no_req", int'(rq_seen[0]), 0);
            chk("retrig_no_write", wr_cnt[0], 0);
            chk("retrig_busy", int'(dma_busy_v[0]), 0);
        end
    endtask

    initial begin
        int n;
        vec_t v;
        for (int i = 0; i < 2; i++) begin
            busak_n_v[i] = 1'b1;
            d1[i] = 1'b1;
            d2[i] = 1'b1;
        end
        clear_mon();
        for (int a = 0; a < 4096; a++) ram[a] = 8'($urandom);

        vecs[0] = '{page: 8,  pause_idx: -1, pause_wr: 0, retrig: 0, retrig_page: 0, exp_cyc: 481};
        vecs[1] = '{page: 8,  pause_idx: -1, pause_wr: 0, retrig: 1, retrig_page: 3, exp_cyc: 481};
        vecs[2] = '{page: 8,  pause_idx: 40, pause_wr: 0, retrig: 0, retrig_page: 0, exp_cyc: 0};
        vecs[3] = '{page: 5,  pause_idx: 77, pause_wr: 1, retrig: 0, retrig_page: 0, exp_cyc: 0};
        vecs[4] = '{page: 15, pause_idx: -1, pause_wr: 0, retrig: 0, retrig_page: 0, exp_cyc: 481};

        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            chk("rst_busrq_n", int'(busrq_n_v[i]), 1);
            chk("rst_obj_we", int'(obj_we_v[i]), 0);
            chk("rst_busy", int'(dma_busy_v[i]), 0);
            chk("rst_src_addr", int'(src_addr_v[i]), 0);
            chk("rst_obj_addr", int'(obj_addr_v[i]), 0);
            chk("rst_obj_dout", int'(obj_dout_v[i]), 0);
        end
        rst_n = 1'b1;
        tick();

        vb_low();
        clear_mon();
        VB = 1'b1;
        repeat (60) tick();
        chk("no_arm_req", int'(rq_seen[0]), 0);
        chk("no_arm_write", wr_cnt[0], 0);
        chk("no_arm_busy", int'(dma_busy_v[0]), 0);

        foreach (vecs[k]) run_transfer(vecs[k]);

        for (int r = 0; r < 4; r++) begin
            v.page        = int'($urandom_range(0, 15));
            v.pause_idx   = (r % 2 == 1) ? int'($urandom_range(1, 158)) : -1;
            v.pause_wr    = 1'($urandom_range(0, 1));
            v.retrig      = 0;
            v.retrig_page = 0;
            v.exp_cyc     = (r % 2 == 1) ? 0 : 481;
            run_transfer(v);
        end

        // Reset in the middle of a copy.
        vb_low();
        clear_mon();
        dma_page = 4'h2;
        dma_trig = 1'b1;
        tick();
        dma_trig = 1'b0;
        VB = 1'b1;
        n = 0;
        while (wr_cnt[0] < 100 && n < 2000) begin
            tick();
            n++;
        end
        chk("reach_idx100", int'(wr_cnt[0] >= 100), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_busrq_n", int'(busrq_n_v[0]), 1);
        chk("midrst_busy", int'(dma_busy_v[0]), 0);
        chk("midrst_obj_we", int'(obj_we_v[0]), 0);
        for (int i = 0; i < 2; i++) begin
            d1[i] = 1'b1;
            d2[i] = 1'b1;
        end
        clear_mon();
        repeat (4) tick();
        rst_n = 1'b1;
        repeat (40) tick();
        chk("postrst_no_write", wr_cnt[0], 0);
        chk("postrst_no_req", int'(rq_seen[0]), 0);
        v = '{page: 2, pause_idx: -1, pause_wr: 0, retrig: 0, retrig_page: 0, exp_cyc: 481};
        run_transfer(v);

        // Arm and VB rise landing on the same clk, short transfer instance.
        n = 0;
        while ((dma_busy_v[0] || dma_busy_v[1]) && n < 200) begin
            tick();
            n++;
        end
        chk("u1_idle", int'(dma_busy_v[1]), 0);
        VB = 1'b0;
        cen_force = 1;
        tick();
        tick();
        clear_mon();
        dma_page = 4'hA;
        dma_trig = 1'b1;
        VB = 1'b1;
        tick();
        dma_trig = 1'b0;
        cen_force = 0;
        chk("same_clk_req_len1", int'(busrq_n_v[1]), 0);
        chk("same_clk_req_len160", int'(busrq_n_v[0]), 0);
        n = 0;
        while (!(t1_seen[0] && t1_seen[1]) && n < 4000) begin
            tick();
            n++;
        end
        chk("len1_timeout", int'(t1_seen[1]), 1);
        chk("len160_timeout", int'(t1_seen[0]), 1);
        check_copy(1, 10, 1, 4);
        check_copy(0, 10, LEN, 481);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
